// File: rtl/axi_lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Response codes, write/read FSM state types and an index-width helper.
package axi_lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // Width of an index into n registers, never zero.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: 32-bit address/data, 2-bit response, no strobes.
// Carries no clock; the owning module supplies it.
interface axi_lite_if;

    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;

    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;

    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;

    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;

    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

endinterface

// File: rtl/axi_lite_reg_decode.sv
// Word-index decoder for the register bank; purely combinational.
// Classifies an index as read-write, read-only or out of range.
module axi_lite_reg_decode
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned NUM_RW_REGS = 8,
    parameter int unsigned NUM_RO_REGS = 8,
    parameter int unsigned DECODE_BITS = 10,
    parameter int unsigned RW_IDX_W    = idx_width(NUM_RW_REGS),
    parameter int unsigned RO_IDX_W    = idx_width(NUM_RO_REGS)
) (
    input  logic [DECODE_BITS-1:0] idx,
    output logic                   is_rw,
    output logic                   is_ro,
    output logic                   hit,
    output logic [RW_IDX_W-1:0]    rw_idx,
    output logic [RO_IDX_W-1:0]    ro_idx
);

    // Zero-extend so the range compare is unsigned and cannot wrap.
    logic [31:0] idx_ext;
    assign idx_ext = 32'(idx);

    assign is_rw  = idx_ext < NUM_RW_REGS;
    assign hit    = idx_ext < (NUM_RW_REGS + NUM_RO_REGS);
    assign is_ro  = hit && !is_rw;
    assign rw_idx = RW_IDX_W'(idx_ext);
    assign ro_idx = RO_IDX_W'(idx_ext - NUM_RW_REGS);

endmodule

// File: rtl/axi_lite_if_reg_slave.sv
// AXI4-Lite responder with a read-write control bank and a read-only status bank.
// Write and read paths are independent two-state FSMs.
module axi_lite_if_reg_slave
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned NUM_RW_REGS  = 8,
    parameter int unsigned NUM_RO_REGS  = 8,
    parameter logic [31:0] RW_RESET_VAL = 32'h0,
    parameter int unsigned DECODE_BITS  = 10
) (
    input  logic                     axil_aclk,
    input  logic                     axil_rst,
    axi_lite_if.slave                s_axil,
    output logic [NUM_RW_REGS*32-1:0] rw_regs,
    output logic [NUM_RW_REGS-1:0]   rw_wr_pulse,
    input  logic [NUM_RO_REGS*32-1:0] ro_regs
);

    localparam int unsigned RW_IDX_W = idx_width(NUM_RW_REGS);
    localparam int unsigned RO_IDX_W = idx_width(NUM_RO_REGS);

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic                   aw_held_q, w_held_q;
    logic [DECODE_BITS-1:0] aw_idx_q;
    logic [31:0]            w_data_q;
    logic [1:0]             b_resp_q;
    logic [31:0]            r_data_q;
    logic [1:0]             r_resp_q;
    logic [31:0]            regs_q [NUM_RW_REGS];
    logic [NUM_RW_REGS-1:0] pulse_q;
    logic [31:0]            ro_words [NUM_RO_REGS];

    logic aw_ready, w_ready, ar_ready, commit;

    logic                wr_is_rw, wr_is_ro, wr_hit;
    logic [RW_IDX_W-1:0] wr_rw_idx;
    logic [RO_IDX_W-1:0] wr_ro_idx;
    logic                rd_is_rw, rd_is_ro, rd_hit;
    logic [RW_IDX_W-1:0] rd_rw_idx;
    logic [RO_IDX_W-1:0] rd_ro_idx;

    axi_lite_reg_decode #(
        .NUM_RW_REGS (NUM_RW_REGS),
        .NUM_RO_REGS (NUM_RO_REGS),
        .DECODE_BITS (DECODE_BITS),
        .RW_IDX_W    (RW_IDX_W),
        .RO_IDX_W    (RO_IDX_W)
    ) u_wr_decode (
        .idx    (aw_idx_q),
        .is_rw  (wr_is_rw),
        .is_ro  (wr_is_ro),
        .hit    (wr_hit),
        .rw_idx (wr_rw_idx),
        .ro_idx (wr_ro_idx)
    );

    axi_lite_reg_decode #(
        .NUM_RW_REGS (NUM_RW_REGS),
        .NUM_RO_REGS (NUM_RO_REGS),
        .DECODE_BITS (DECODE_BITS),
        .RW_IDX_W    (RW_IDX_W),
        .RO_IDX_W    (RO_IDX_W)
    ) u_rd_decode (
        .idx    (s_axil.ar_addr[DECODE_BITS+1:2]),
        .is_rw  (rd_is_rw),
        .is_ro  (rd_is_ro),
        .hit    (rd_hit),
        .rw_idx (rd_rw_idx),
        .ro_idx (rd_ro_idx)
    );

    for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_rw_out
        assign rw_regs[32*i +: 32] = regs_q[i];
    end

    for (genvar i = 0; i < NUM_RO_REGS; i++) begin : g_ro_in
        assign ro_words[i] = ro_regs[32*i +: 32];
    end

    // Write FSM: capture AW/W independently, commit once both are held.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        commit     = 1'b0;
        unique case (wr_state_q)
            WR_IDLE: begin
                aw_ready = !aw_held_q;
                w_ready  = !w_held_q;
                if (aw_held_q && w_held_q) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axil.b_ready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            pulse_q    <= '0;
            for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= RW_RESET_VAL;
        end else begin
            wr_state_q <= wr_state_d;
            pulse_q    <= '0;
            if (aw_ready && s_axil.aw_valid) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= s_axil.aw_addr[DECODE_BITS+1:2];
            end
            if (w_ready && s_axil.w_valid) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axil.w_data;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                b_resp_q  <= (wr_hit && !wr_is_ro) ? RESP_OKAY : RESP_SLVERR;
                if (wr_is_rw) begin
                    regs_q[wr_rw_idx]  <= w_data_q;
                    pulse_q[wr_rw_idx] <= 1'b1;
                end
            end
        end
    end

    // Read FSM: data is registered on the AR handshake edge.
    always_comb begin
        rd_state_d = rd_state_q;
        ar_ready   = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                ar_ready = 1'b1;
                if (s_axil.ar_valid) rd_state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axil.r_ready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            rd_state_q <= RD_IDLE;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_ready && s_axil.ar_valid) begin
                r_resp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                if (rd_is_rw)      r_data_q <= regs_q[rd_rw_idx];
                else if (rd_is_ro) r_data_q <= ro_words[rd_ro_idx];
                else               r_data_q <= '0;
            end
        end
    end

    assign s_axil.aw_ready = aw_ready;
    assign s_axil.w_ready  = w_ready;
    assign s_axil.b_valid  = (wr_state_q == WR_RESP);
    assign s_axil.b_resp   = b_resp_q;
    assign s_axil.ar_ready = ar_ready;
    assign s_axil.r_valid  = (rd_state_q == RD_RESP);
    assign s_axil.r_data   = r_data_q;
    assign s_axil.r_resp   = r_resp_q;
    assign rw_wr_pulse     = pulse_q;

endmodule

// File: tb/tb_axi_lite_if_reg_slave.sv
// Randomized self-checking bench for axi_lite_if_reg_slave.
// Reference model: a plain array of register values plus the bus timing rules.
module tb_axi_lite_if_reg_slave;

    localparam int unsigned NRW = 8;
    localparam int unsigned NRO = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NRW*32-1:0]  rw_regs;
    logic [NRW-1:0]     rw_wr_pulse;
    logic [NRO*32-1:0]  ro_regs;

    logic [31:0] model_regs [NRW];
    logic [31:0] ro_vals [NRO];

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_if bus();

    axi_lite_if_reg_slave #(
        .NUM_RW_REGS  (NRW),
        .NUM_RO_REGS  (NRO),
        .RW_RESET_VAL (32'h0),
        .DECODE_BITS  (10)
    ) dut (
        .axil_aclk   (clk),
        .axil_rst    (rst),
        .s_axil      (bus),
        .rw_regs     (rw_regs),
        .rw_wr_pulse (rw_wr_pulse),
        .ro_regs     (ro_regs)
    );

    always #5 clk = ~clk;

    always_comb begin
        ro_regs = '0;
        for (int i = 0; i < NRO; i++) ro_regs[32*i +: 32] = ro_vals[i];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NRW; i++)
            check_eq($sformatf("%s rw_regs[%0d]", tag, i), rw_regs[32*i +: 32], model_regs[i]);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " aw_ready"}, 32'(bus.aw_ready), 32'd1);
        check_eq({tag, " w_ready"},  32'(bus.w_ready),  32'd1);
        check_eq({tag, " ar_ready"}, 32'(bus.ar_ready), 32'd1);
        check_eq({tag, " b_valid"},  32'(bus.b_valid),  32'd0);
        check_eq({tag, " r_valid"},  32'(bus.r_valid),  32'd0);
        check_eq({tag, " pulse"},    32'(rw_wr_pulse),  32'd0);
    endtask

    // Full write transaction; called and returns at a negedge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
        int unsigned idx = 32'(addr[11:2]);
        bit ok = (idx < NRW);
        logic [31:0] exp_resp = ok ? 32'd0 : 32'd2;
        logic [31:0] exp_pulse = ok ? (32'd1 << idx) : 32'd0;
        bit aw_done = 0, w_done = 0, done = 0;
        int aw_n = 0, w_n = 0, first_b = -1, n = 0;
        while (!done && n < 64) begin
            bus.aw_valid = !aw_done && n >= aw_dly;
            bus.aw_addr  = addr;
            bus.w_valid  = !w_done && n >= w_dly;
            bus.w_data   = data;
            bus.b_ready  = n >= b_dly;
            check_eq("wr aw_ready", 32'(bus.aw_ready), 32'(!aw_done));
            check_eq("wr w_ready",  32'(bus.w_ready),  32'(!w_done));
            if (bus.b_valid) begin
                check_eq("wr b_resp", 32'(bus.b_resp), exp_resp);
                if (first_b < 0) begin
                    first_b = n;
                    check_eq("wr latency", 32'(n), 32'((aw_n > w_n ? aw_n : w_n) + 2));
                    check_eq("wr pulse", 32'(rw_wr_pulse), exp_pulse);
                end else begin
                    check_eq("wr pulse width", 32'(rw_wr_pulse), 32'd0);
                end
                if (bus.b_ready) done = 1;
            end else begin
                check_eq("wr early pulse", 32'(rw_wr_pulse), 32'd0);
            end
            if (bus.aw_valid && bus.aw_ready) begin aw_done = 1; aw_n = n; end
            if (bus.w_valid && bus.w_ready) begin w_done = 1; w_n = n; end
            @(negedge clk);
            n++;
        end
        bus.aw_valid = 0;
        bus.w_valid  = 0;
        bus.b_ready  = 0;
        if (!done) check_eq("wr timeout", 32'd0, 32'd1);
        if (ok) model_regs[idx] = data;
        check_eq("wr b_valid drop", 32'(bus.b_valid), 32'd0);
        check_eq("wr pulse after", 32'(rw_wr_pulse), 32'd0);
        check_regs("wr");
    endtask

    // Full read transaction; called and returns at a negedge.
    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        int unsigned idx = 32'(addr[11:2]);
        logic [31:0] exp_data;
        logic [31:0] exp_resp;
        bit ar_done = 0, done = 0, seen = 0;
        int ar_n = 0, n = 0;
        if (idx < NRW) begin
            exp_data = model_regs[idx]; exp_resp = 0;
        end else if (idx < NRW + NRO) begin
            exp_data = ro_vals[idx - NRW]; exp_resp = 0;
        end else begin
            exp_data = 0; exp_resp = 2;
        end
        while (!done && n < 64) begin
            bus.ar_valid = !ar_done && n >= ar_dly;
            bus.ar_addr  = addr;
            bus.r_ready  = n >= r_dly;
            check_eq("rd ar_ready", 32'(bus.ar_ready), 32'(!ar_done));
            if (bus.r_valid) begin
                if (!seen) check_eq("rd latency", 32'(n), 32'(ar_n + 1));
                seen = 1;
                check_eq("rd r_data", bus.r_data, exp_data);
                check_eq("rd r_resp", 32'(bus.r_resp), exp_resp);
                if (bus.r_ready) done = 1;
            end
            if (bus.ar_valid && bus.ar_ready) begin ar_done = 1; ar_n = n; end
            @(negedge clk);
            n++;
        end
        bus.ar_valid = 0;
        bus.r_ready  = 0;
        if (!done) check_eq("rd timeout", 32'd0, 32'd1);
        check_eq("rd r_valid drop", 32'(bus.r_valid), 32'd0);
    endtask

    initial begin
        bus.aw_valid = 0; bus.aw_addr = 0; bus.w_valid = 0; bus.w_data = 0;
        bus.b_ready = 0; bus.ar_valid = 0; bus.ar_addr = 0; bus.r_ready = 0;
        for (int i = 0; i < NRO; i++) ro_vals[i] = 32'h1000_0000 + i;
        for (int i = 0; i < NRW; i++) model_regs[i] = 0;

        repeat (3) @(negedge clk);
        check_idle("reset");
        check_eq("reset b_resp", 32'(bus.b_resp), 32'd0);
        check_eq("reset r_data", bus.r_data, 32'd0);
        check_eq("reset r_resp", 32'(bus.r_resp), 32'd0);
        check_regs("reset");
        rst = 0;
        @(negedge clk);

        // AW and W together, immediate B acceptance
        do_write(32'h008, 32'hA5A5_0001, 0, 0, 0);
        // W well ahead of AW, B back-pressured
        do_write(32'h004, 32'h0000_1234, 3, 0, 9);
        do_read(32'h004, 0, 0);

        // Read-only bank read, then rejected write to it
        ro_vals[1] = 32'hCAFE_F00D;
        do_read(32'h024, 0, 0);
        do_write(32'h024, 32'hDEAD_BEEF, 0, 1, 0);

        // Out-of-range index 64
        do_read(32'h100, 1, 2);
        do_write(32'h100, 32'h5555_AAAA, 1, 0, 1);

        // Read on the commit edge sees the old value
        do_write(32'h000, 32'd5, 0, 0, 0);
        bus.aw_valid = 1; bus.aw_addr = 32'h000; bus.w_valid = 1; bus.w_data = 32'h77;
        @(negedge clk);
        bus.aw_valid = 0; bus.w_valid = 0;
        bus.ar_valid = 1; bus.ar_addr = 32'h000; bus.r_ready = 1; bus.b_ready = 1;
        @(negedge clk);
        bus.ar_valid = 0;
        check_eq("race b_valid", 32'(bus.b_valid), 32'd1);
        check_eq("race r_valid", 32'(bus.r_valid), 32'd1);
        check_eq("race r_data old", bus.r_data, 32'd5);
        @(negedge clk);
        bus.r_ready = 0; bus.b_ready = 0;
        model_regs[0] = 32'h77;
        check_regs("race");
        do_read(32'h000, 0, 0);

        // Randomized mixed traffic
        for (int t = 0; t < 60; t++) begin
            int unsigned sel = $urandom_range(0, 9);
            int unsigned idx;
            logic [31:0] addr;
            for (int i = 0; i < NRO; i++) ro_vals[i] = $urandom;
            if (sel < 8) idx = $urandom_range(0, 17);
            else idx = $urandom_range(0, 1023);
            addr = ($urandom & 32'hFFFF_F000) | (idx << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 6));
            else
                do_read(addr, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while both paths sit in their response states
        bus.aw_valid = 1; bus.aw_addr = 32'h00C; bus.w_valid = 1; bus.w_data = 32'h1357_9BDF;
        bus.ar_valid = 1; bus.ar_addr = 32'h000;
        @(negedge clk);
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
        for (int i = 0; i < 10 && !(bus.b_valid && bus.r_valid); i++) @(negedge clk);
        check_eq("rst pre b_valid", 32'(bus.b_valid), 32'd1);
        check_eq("rst pre r_valid", 32'(bus.r_valid), 32'd1);
        rst = 1;
        @(negedge clk);
        for (int i = 0; i < NRW; i++) model_regs[i] = 0;
        check_idle("mid rst");
        check_regs("mid rst");
        rst = 0;
        bus.b_ready = 1; bus.r_ready = 1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post rst b_valid", 32'(bus.b_valid), 32'd0);
            check_eq("post rst r_valid", 32'(bus.r_valid), 32'd0);
        end
        bus.b_ready = 0; bus.r_ready = 0;
        do_read(32'h00C, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
